// File: rtl/cep_define.sv
// Shared PMP definitions: A-mode codes, access types, cfg bit positions, scan FSM states.
package cep_define;

    // Address-matching modes held in cfg bits [4:3]
    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] TOR   = 2'd1;
    localparam logic [1:0] NA4   = 2'd2;
    localparam logic [1:0] NAPOT = 2'd3;

    // Access types carried on req_type; code 3 is illegal
    localparam logic [1:0] ACC_R = 2'd0;
    localparam logic [1:0] ACC_W = 2'd1;
    localparam logic [1:0] ACC_X = 2'd2;

    // Bit positions inside one pmpcfg byte
    localparam int unsigned CFG_R    = 0;
    localparam int unsigned CFG_W    = 1;
    localparam int unsigned CFG_X    = 2;
    localparam int unsigned CFG_A_LO = 3;
    localparam int unsigned CFG_L    = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } pmp_scan_state_t;

endpackage

// File: rtl/addr_check_n.sv
// Combinational range check of one access against one PMP entry (pmpaddr holds byte address >> 2).
module addr_check_n
    import cep_define::*;
(
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_n_i,
    input  logic [31:0] addr_n_1_i,
    input  logic [1:0]  a_n_i,
    output logic        match_o
);

    logic [33:0] start_a;
    logic [33:0] end_a;
    logic [33:0] lo;
    logic [33:0] hi;
    logic [31:0] mask;

    // Whole access (first..last byte) must fall inside the entry's region
    always_comb begin
        start_a = {2'b00, addr_i};
        end_a   = start_a + ((34'd1 << size_i) - 34'd1);
        lo      = {addr_n_1_i, 2'b00};
        hi      = {addr_n_i, 2'b00};
        mask    = addr_n_i ^ (addr_n_i + 32'd1);
        match_o = 1'b0;
        case (a_n_i)
            OFF:     match_o = 1'b0;
            TOR:     match_o = (start_a >= lo) && (end_a < hi);
            NA4:     match_o = (start_a[33:2] == addr_n_i) && (end_a[33:2] == addr_n_i);
            NAPOT:   match_o = ((start_a[33:2] | mask) == (addr_n_i | mask)) &&
                               ((end_a[33:2]   | mask) == (addr_n_i | mask));
            default: match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: walks entries one per cycle through a shared addr_check_n.
module pmp_scan_ctrl
    import cep_define::*;
#(
    parameter int unsigned N_ENTRIES = 16,
    parameter int unsigned IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic [1:0]              req_size,
    input  logic [1:0]              req_type,
    input  logic                    req_priv,
    input  logic [8*N_ENTRIES-1:0]  pmpcfg_i,
    input  logic [32*N_ENTRIES-1:0] pmpaddr_i,
    input  logic                    cfg_write,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_fault,
    output logic                    resp_hit,
    output logic [IDX_W-1:0]        resp_entry
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    pmp_scan_state_t  state_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic [1:0]       type_q;
    logic             priv_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_fault_q;
    logic             resp_hit_q;
    logic [IDX_W-1:0] resp_entry_q;

    logic [7:0]  cfg_arr  [N_ENTRIES];
    logic [31:0] addr_arr [N_ENTRIES];

    logic [7:0]  cfg_sel;
    logic [31:0] addr_n;
    logic [31:0] addr_n_1;
    logic        match;
    logic        perm;
    logic        illegal;
    logic        fault_hit;
    logic        fault_miss;
    logic        unused_cfg_bits;

    // Unpack the flat CSR buses into per-entry views
    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_unpack
        assign cfg_arr[g]  = pmpcfg_i[8*g +: 8];
        assign addr_arr[g] = pmpaddr_i[32*g +: 32];
    end

    // Select the entry under test and derive its permission outcome
    always_comb begin
        cfg_sel  = cfg_arr[idx_q];
        addr_n   = addr_arr[idx_q];
        addr_n_1 = (idx_q == '0) ? 32'h0 : addr_arr[idx_q - IDX_W'(1)];
        case (type_q)
            ACC_R:   perm = cfg_sel[CFG_R];
            ACC_W:   perm = cfg_sel[CFG_W];
            ACC_X:   perm = cfg_sel[CFG_X];
            default: perm = 1'b0;
        endcase
        illegal    = (type_q == 2'd3);
        fault_hit  = illegal | ((priv_q && !cfg_sel[CFG_L]) ? 1'b0 : !perm);
        fault_miss = illegal | !priv_q;
    end

    assign unused_cfg_bits = ^cfg_sel[6:5];

    addr_check_n u_addr_check (
        .addr_i     (addr_q),
        .size_i     (size_q),
        .addr_n_i   (addr_n),
        .addr_n_1_i (addr_n_1),
        .a_n_i      (cfg_sel[CFG_A_LO +: 2]),
        .match_o    (match)
    );

    // Scan FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            type_q       <= '0;
            priv_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_entry_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        type_q      <= req_type;
                        priv_q      <= req_priv;
                        idx_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (cfg_write) begin
                        idx_q <= '0;
                    end else if (match) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_entry_q <= idx_q;
                        resp_fault_q <= fault_hit;
                        state_q      <= RESP;
                    end else if (idx_q == LAST_IDX) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b0;
                        resp_entry_q <= '0;
                        resp_fault_q <= fault_miss;
                        state_q      <= RESP;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_hit   = resp_hit_q;
    assign resp_entry = resp_entry_q;

endmodule

// File: doc/pmp_scan_ctrl.md
Name: pmp_scan_ctrl

Overview:
- Sequential PMP permission checker that sits between the LSU/fetch request and the memory bus.
- Accepts one access request at a time and walks the PMP entries one per cycle through a single shared addr_check_n instance.
- Stops at the lowest-numbered matching entry, then applies the R/W/X/L permission rules.
- Returns allow/fault over a valid/ready response handshake.

Parameters:
- N_ENTRIES, 16: number of PMP entries scanned. Range 1..16.
- IDX_W, $clog2(N_ENTRIES) (min 1): width of the entry index.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- req_valid  input  1  access request valid
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_addr  input  32  access address
- req_size  input  2  access size code, forwarded to addr_check_n
- req_type  input  2  access type: 0=R, 1=W, 2=X; 3 is illegal and always faults
- req_priv  input  1  1=M-mode, 0=U-mode
- pmpcfg_i  input  8*N_ENTRIES  cfg byte per entry; entry i uses bits [8i+7:8i]. Byte layout: bit0 R, bit1 W, bit2 X, bits4:3 A mode, bit7 L.
- pmpaddr_i  input  32*N_ENTRIES  pmpaddr per entry; entry i uses bits [32i+31:32i]
- cfg_write  input  1  pulse: CSR file wrote any pmpcfg/pmpaddr this cycle
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_fault  output  1  1 = access denied
- resp_hit  output  1  1 = some entry matched
- resp_entry  output  IDX_W  index of the matching entry; 0 when resp_hit=0

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_hit=0, resp_entry=0, index counter=0, latched request cleared. Reset in any state aborts the current check; no response is produced for it.
- States:
  - IDLE -> SCAN on req_valid&&req_ready. addr/size/type/priv are latched and idx=0.
  - SCAN evaluates entry idx each cycle:
    - addr_n = pmpaddr[idx].
    - addr_n_1 = pmpaddr[idx-1], or 32'h0 when idx=0.
    - a_n = cfg[idx][4:3].
  - SCAN: match -> RESP, hit=1, entry=idx.
  - SCAN: no match and idx==N_ENTRIES-1 -> RESP, hit=0.
  - SCAN: otherwise idx++.
  - RESP: hold all resp_* stable while resp_valid=1 and resp_ready=0; go to IDLE on resp_ready.
- Latency: a match on entry k gives resp_valid k+1 cycles after the accept cycle. A miss gives resp_valid N_ENTRIES cycles after accept. Back-to-back requests are not overlapped: req_ready is 0 from the accept cycle through the RESP handshake cycle.
- Entries with A=OFF never match. The scan continues past them.
- Permission rules (hit; p = R/W/X bit selected by type):
  - U-mode: fault = !p.
  - M-mode with L=1: fault = !p.
  - M-mode with L=0: fault = 0.
- Permission rules (no hit): M-mode fault=0; U-mode fault=1.
- req_type==3 always faults, with hit and entry reported normally.
- cfg_write while in SCAN: idx resets to 0 and the scan restarts with the latched request, so the result always reflects the post-write config. cfg_write in IDLE or RESP is ignored; a result already in RESP is not recomputed.
- cfg_write in the same cycle as a match: the restart wins and no RESP is entered that cycle.
- The index counter must never exceed N_ENTRIES-1, and there is no wrap-around within one scan.

Decomposition:
- Shared package cep_define holds:
  - existing A-mode constants OFF/TOR/NA4/NAPOT;
  - new access-type constants ACC_R=0, ACC_W=1, ACC_X=2;
  - cfg bit positions CFG_R=0, CFG_W=1, CFG_X=2, CFG_A_LO=3, CFG_L=7;
  - the state enum typedef pmp_scan_state_t {IDLE, SCAN, RESP}.
- Sub-module: exactly one addr_check_n instance, time-shared across entries. Entry selection muxes are local to pmp_scan_ctrl.

Test Plan:
1. Entry 2 NAPOT 0x8000_0000/4KB, cfg R=1 W=0 L=0; U-mode write to 0x8000_0010 -> resp_hit=1, entry=2, fault=1, resp_valid 3 cycles after accept.
2. All entries OFF; M-mode read 0x1234_5678 -> hit=0, fault=0 after 16 cycles. Same request in U-mode -> hit=0, fault=1.
3. Entry 0 TOR, pmpaddr0 covering 0..0x1000, cfg X=1 L=1; M-mode exec at 0x800 -> hit, entry=0, fault=0. The same with X=0 -> fault=1.
4. Entries 1 and 3 both match 0x2000, entry 1 R=0 and entry 3 R=1; U-mode read -> entry=1, fault=1 (lowest index wins).
5. Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, a new req_valid is not accepted. Then resp_ready=1 -> IDLE the next cycle.
6. During SCAN at idx=5, pulse cfg_write that enables entry 0 to match -> scan restarts and responds with entry=0. Also assert rst mid-SCAN -> next cycle resp_valid=0, req_ready=1.
